// File: rtl/booth_radix4_seq.sv
// Sequential radix-4 Booth multiplier with a req/ack handshake on both sides.
// One Booth digit is retired per clock while in CALC; the product is held in SUM until the next completion.
module booth_radix4_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_inX,
  input  logic [WIDTH-1:0]     data_inY,
  input  logic                 sign_mode,
  input  logic                 Rin,
  output logic                 Ain,
  output logic                 Rout,
  input  logic                 Aout,
  output logic [2*WIDTH-1:0]   SUM
);

  localparam int ITER = (WIDTH + 2) / 2;
  localparam int EW   = WIDTH + 2;
  localparam int AW   = 2 * EW;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] xs;
  logic [AW-1:0] acc;
  logic [AW-1:0] pp;
  logic [AW-1:0] acc_nxt;
  logic [EW-1:0] yr;
  logic          yprev;
  logic [CW-1:0] cnt;
  logic [2:0]    trip;
  logic [EW-1:0] xext;
  logic [EW-1:0] yext;

  assign xext = {{2{sign_mode & data_inX[WIDTH-1]}}, data_inX};
  assign yext = {{2{sign_mode & data_inY[WIDTH-1]}}, data_inY};

  assign Ain  = (state == IDLE);
  assign Rout = (state == DONE);

  // xs is pre-shifted each step, so the digit weight 4^i is applied by shifting rather than by indexing.
  assign trip = {yr[1:0], yprev};

  always_comb begin
    pp = '0;
    case (trip)
      3'b001, 3'b010: pp = xs;
      3'b011:         pp = xs << 1;
      3'b100:         pp = -(xs << 1);
      3'b101, 3'b110: pp = -xs;
      default:        pp = '0;
    endcase
    acc_nxt = acc + pp;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      xs    <= '0;
      acc   <= '0;
      yr    <= '0;
      yprev <= 1'b0;
      cnt   <= '0;
      SUM   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Rin) begin
            xs    <= {{EW{xext[EW-1]}}, xext};
            yr    <= yext;
            yprev <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_nxt;
          xs    <= xs << 2;
          yr    <= yr >> 2;
          yprev <= yr[1];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            SUM   <= acc_nxt[2*WIDTH-1:0];
            state <= DONE;
          end
        end
        DONE: begin
          if (Aout) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_seq.sv
// Self-checking bench for booth_radix4_seq (WIDTH=32): directed corner cases plus random
// transactions checked against a plain-arithmetic product model.
module tb_booth_radix4_seq;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   data_inX;
  logic [W-1:0]   data_inY;
  logic           sign_mode;
  logic           Rin;
  logic           Ain;
  logic           Rout;
  logic           Aout;
  logic [2*W-1:0] SUM;

  int n_assert = 0;
  int n_fail   = 0;

  booth_radix4_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_inX  (data_inX),
    .data_inY  (data_inY),
    .sign_mode (sign_mode),
    .Rin       (Rin),
    .Ain       (Ain),
    .Rout      (Rout),
    .Aout      (Aout),
    .SUM       (SUM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    logic signed [63:0] a;
    logic signed [63:0] b;
    if (sm) begin
      a = {{W{x[W-1]}}, x};
      b = {{W{y[W-1]}}, y};
      return a * b;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // One full transaction from the IDLE state, with inputs driven at negedges.
  task automatic run(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic sm, input logic [63:0] exp, input int hold);
    logic [63:0] prev;
    int cyc;
    prev = SUM;
    chk({tag, "_ain_idle"}, Ain, 1'b1);
    data_inX = x; data_inY = y; sign_mode = sm; Rin = 1'b1; Aout = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (Rout !== 1'b1 && cyc < 40) begin
      // Scramble inputs while busy: all of them must be ignored.
      data_inX  = $urandom;
      data_inY  = $urandom;
      sign_mode = 1'($urandom_range(0, 1));
      Rin       = 1'($urandom_range(0, 1));
      Aout      = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      if (cyc == 3) begin
        chk({tag, "_ain_calc"}, Ain, 1'b0);
        chk({tag, "_sum_hold_calc"}, SUM, prev);
      end
    end
    Rin = 1'b0; Aout = 1'b0;
    chk({tag, "_latency"}, cyc, 17);
    chk(tag, SUM, exp);
    for (int h = 0; h < hold; h++) begin
      Rin = h[0];
      data_inX = $urandom;
      @(negedge clk);
      chk({tag, "_bp_rout"}, Rout, 1'b1);
      chk({tag, "_bp_ain"}, Ain, 1'b0);
      chk({tag, "_bp_sum"}, SUM, exp);
    end
    Rin = 1'b0; Aout = 1'b1;
    @(negedge clk);
    Aout = 1'b0;
    chk({tag, "_rel_rout"}, Rout, 1'b0);
    chk({tag, "_rel_ain"}, Ain, 1'b1);
    chk({tag, "_rel_sum"}, SUM, exp);
    @(negedge clk);
    chk({tag, "_no_queue"}, Ain, 1'b1);
  endtask

  initial begin
    int cyc;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         rs;
    reset = 1'b1; Rin = 1'b0; Aout = 1'b0;
    data_inX = '0; data_inY = '0; sign_mode = 1'b0;

    #2 reset = 1'b0;
    #1;
    chk("rst_ain", Ain, 1'b1);
    chk("rst_rout", Rout, 1'b0);
    chk("rst_sum", SUM, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ain", Ain, 1'b1);
    chk("post_rst_rout", Rout, 1'b0);
    chk("post_rst_sum", SUM, 64'h0);

    run("neg3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    run("ff_u", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0);
    run("ff_s", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1);
    run("min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
    run("max_min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, 0);
    run("backpressure", 32'd1000, 32'd3, 1'b0, 64'd3000, 5);

    // Abort mid-CALC with reset: no result may appear and SUM must clear.
    data_inX = 32'd99; data_inY = 32'd77; sign_mode = 1'b0; Rin = 1'b1;
    @(negedge clk);
    Rin = 1'b0;
    repeat (5) @(negedge clk);
    data_inX = 32'hDEAD_BEEF; data_inY = 32'h1234_5678;
    reset = 1'b0;
    #1;
    chk("abort_ain", Ain, 1'b1);
    chk("abort_rout", Rout, 1'b0);
    chk("abort_sum", SUM, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (Rout === 1'b1) cyc++;
    end
    chk("abort_no_rout", cyc, 0);
    chk("abort_sum_after", SUM, 64'h0);
    run("post_abort", 32'd12345, 32'd6789, 1'b0, 64'd83810205, 0);

    for (int i = 0; i < 20; i++) begin
      rx = $urandom;
      ry = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i == 0) rx = '0;
      run($sformatf("rand%0d", i), rx, ry, rs, model(rx, ry, rs), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_radix4_seq.md
BOOTH_RADIX4_SEQ -- requirements
Module: booth_radix4_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits; legal values are even and >= 4.
REQ-002 The block SHALL have derived localparam ITER, equal to (WIDTH+2)/2, the number of radix-4 digit steps.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port data_inX  input  WIDTH  multiplicand.
REQ-006 The block SHALL have port data_inY  input  WIDTH  multiplier.
REQ-007 The block SHALL have port sign_mode  input  1  1 = operands signed two's complement; 0 = operands unsigned.
REQ-008 The block SHALL have port Rin  input  1  producer request: operands and sign_mode valid.
REQ-009 The block SHALL have port Ain  output  1  acknowledge / ready to producer.
REQ-010 The block SHALL have port Rout  output  1  result valid to consumer.
REQ-011 The block SHALL have port Aout  input  1  consumer acknowledge of result.
REQ-012 The block SHALL have port SUM  output  2*WIDTH  product, signed or unsigned per captured sign_mode.

Function
REQ-013 The block SHALL implement an FSM with exactly three states: IDLE, CALC, DONE.
REQ-014 Ain SHALL be a combinational decode of the state: 1 in IDLE, 0 otherwise.
REQ-015 Rout SHALL be a combinational decode of the state: 1 in DONE, 0 otherwise.
REQ-016 IDLE -> CALC SHALL occur on the rising edge where Rin=1 and Ain=1 (the accept edge).
REQ-017 On the accept edge the block SHALL capture data_inX, data_inY and sign_mode, and clear the accumulator and digit counter.
REQ-018 Operand and mode inputs SHALL be ignored on all edges other than the accept edge.
REQ-019 Operands SHALL be extended internally to WIDTH+2 bits: sign-extended when sign_mode=1, zero-extended when sign_mode=0.
REQ-020 Each CALC edge SHALL retire one radix-4 Booth digit from multiplier bit triplet (y[2i+1], y[2i], y[2i-1]), with y[-1]=0.
REQ-021 Digit recoding SHALL be: 000/111 -> 0, 001/010 -> +X, 011 -> +2X, 100 -> -2X, 101/110 -> -X.
REQ-022 Partial products SHALL be formed at full internal width with no truncation before the final result.
REQ-023 After ITER CALC edges the FSM SHALL enter DONE, and SUM SHALL load the low 2*WIDTH bits of the accumulator on that same edge.
REQ-024 Rout SHALL therefore rise exactly ITER cycles after the accept edge (17 for WIDTH=32).
REQ-025 DONE -> IDLE SHALL occur on the rising edge where Aout=1; Aout=0 SHALL hold DONE indefinitely.
REQ-026 SUM SHALL be written only on entry to DONE and SHALL hold its value through DONE, IDLE and the next CALC.
REQ-027 Rin while in CALC or DONE SHALL be ignored, with no queuing.
REQ-028 Aout while in IDLE or CALC SHALL be ignored.
REQ-029 A new request SHALL be accepted no earlier than the edge after DONE -> IDLE, giving a minimum initiation interval of ITER+2 cycles.
REQ-030 The product SHALL be exact for all operands in both modes; the block has no overflow condition.

Reset
REQ-031 reset=0 SHALL immediately (asynchronously) force IDLE and clear SUM, the accumulator and the counter to 0, giving Ain=1 and Rout=0.
REQ-032 reset asserted mid-CALC or in DONE SHALL discard the operation with no output pulse.
REQ-033 After reset deasserts, the first rising edge with Rin=1 SHALL be a valid accept edge.

Verification (WIDTH=32)
REQ-034 The bench SHALL cover: reset low for 1 cycle -> Ain=1, Rout=0, SUM=0 during and after reset.
REQ-035 The bench SHALL cover: sign_mode=1, X=0xFFFFFFFD (-3), Y=7 -> Rout rises 17 cycles after accept, SUM=0xFFFFFFFFFFFFFFEB (-21).
REQ-036 The bench SHALL cover: X=Y=0xFFFFFFFF -> SUM=0xFFFFFFFE00000001 with sign_mode=0, and SUM=0x0000000000000001 with sign_mode=1.
REQ-037 The bench SHALL cover: sign_mode=1, X=Y=0x80000000 -> SUM=0x4000000000000000; also X=0x7FFFFFFF, Y=0x80000000 -> SUM=0xC000000080000000.
REQ-038 The bench SHALL cover back-pressure: Aout=0 for 5 cycles in DONE with Rin pulsed -> Rout=1 throughout, SUM stable, Ain=0; then Aout=1 -> next edge Rout=0, Ain=1, SUM unchanged.
REQ-039 The bench SHALL cover: reset pulsed at CALC cycle 5, operands changed mid-CALC -> Rout never rises, SUM=0; next transaction 12345*6789 unsigned -> SUM=83810205.
